// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-masked stores and combinational loads,
// plus an MMIO window (TX byte FIFO, 64-bit mtime) built only when DMEM_MMIO_EN is defined.
module dmem_responder #(
    parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter logic [31:0] MMIO_BASE  = 32'hA000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dram_en,
    input  logic        dram_wen,
    input  logic [31:0] dram_addr,
    input  logic [31:0] dram_wdata,
    input  logic [3:0]  dram_wmask,
    output logic [31:0] dram_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        err
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_SPAN = 32'(4 * MEM_WORDS);

    logic [31:0]   ram_off;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic          rd_req;
    logic          wr_req;
    logic          mmio_hit;
    logic [31:0]   mmio_rdata;
    logic          err_q;
    logic [31:0]   mem_q [MEM_WORDS];

    // Unsigned wrap of the subtraction makes addresses below RAM_BASE miss as well.
    assign ram_off = dram_addr - RAM_BASE;
    assign ram_hit = ram_off < RAM_SPAN;
    assign ram_idx = ram_off[AW+1:2];
    assign rd_req  = dram_en & ~dram_wen;
    assign wr_req  = dram_en & dram_wen;

    always_ff @(posedge clk) begin
        if (wr_req && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (dram_wmask[b]) begin
                    mem_q[ram_idx][8*b +: 8] <= dram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        dram_rdata = '0;
        if (rst && rd_req) begin
            if (ram_hit) begin
                dram_rdata = mem_q[ram_idx];
            end else if (mmio_hit) begin
                dram_rdata = mmio_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (dram_en && !ram_hit && !mmio_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

`ifdef DMEM_MMIO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [1:0]    mmio_off;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic [7:0]    count8;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [31:0]   hi_shadow_q, hi_shadow_d;

    assign mmio_hit = dram_addr[31:4] == MMIO_BASE[31:4];
    assign mmio_off = dram_addr[3:2];
    assign count8   = 8'(count_q);

    assign full     = count_q == CW'(FIFO_DEPTH);
    assign tx_valid = count_q != '0;
    assign tx_data  = fifo_q[rd_ptr_q];
    assign pop      = tx_valid & tx_ready;
    assign push_req = wr_req & mmio_hit & (mmio_off == 2'd0) & dram_wmask[0];
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok  = push_req & (~full | pop);

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            2'd1:    mmio_rdata = {23'b0, count8, ovf_q};
            2'd2:    mmio_rdata = mtime_q[31:0];
            2'd3:    mmio_rdata = hi_shadow_q;
            default: mmio_rdata = '0;
        endcase
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        mtime_d     = mtime_q + 64'd1;
        hi_shadow_d = hi_shadow_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (wr_req && mmio_hit && mmio_off == 2'd1 && dram_wmask[0] && dram_wdata[0]) begin
            ovf_d = 1'b0;
        end

        if (wr_req && mmio_hit && (dram_wmask != 4'b0000)) begin
            if (mmio_off == 2'd2) begin
                mtime_d = {mtime_q[63:32], dram_wdata};
            end else if (mmio_off == 2'd3) begin
                mtime_d = {dram_wdata, mtime_q[31:0]};
            end
        end

        // Reading the low half freezes the matching high half for a torn-free pair.
        if (rd_req && mmio_hit && mmio_off == 2'd2) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            mtime_q     <= '0;
            hi_shadow_q <= '0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= dram_wdata[7:0];
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            mtime_q     <= mtime_d;
            hi_shadow_q <= hi_shadow_d;
        end
    end
`else
    logic unused_tx_ready;

    assign mmio_hit        = 1'b0;
    assign mmio_rdata      = '0;
    assign tx_valid        = 1'b0;
    assign tx_data         = '0;
    assign unused_tx_ready = tx_ready;
`endif

endmodule
